// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register: register-file read, RAW hazard interlock, MEM/WB bypass.
// Define ID_EX_BYPASS_EN to enable the bypass muxes; otherwise dependents stall until retirement.
module id_ex_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic              in_use_rs1,
  input  logic              in_use_rs2,
  input  logic              in_rd_we,
  input  logic              in_is_load,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [4:0]        rf_a1,
  output logic [4:0]        rf_a2,
  input  logic [XLEN-1:0]   rf_d1,
  input  logic [XLEN-1:0]   rf_d2,
  input  logic [4:0]        mem_rd,
  input  logic              mem_we,
  input  logic              mem_is_load,
  input  logic [XLEN-1:0]   mem_wd,
  input  logic [4:0]        wb_rd,
  input  logic              wb_we,
  input  logic [XLEN-1:0]   wb_wd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_op1,
  output logic [XLEN-1:0]   out_op2,
  output logic [XLEN-1:0]   out_imm,
  output logic [4:0]        out_rd,
  output logic              out_rd_we,
  output logic              out_is_load,
  output logic [CTRL_W-1:0] out_ctrl
);

  logic            adv;
  logic            live1, live2;
  logic            haz1, haz2;
  logic            capture;
  logic [XLEN-1:0] op1, op2;

  assign rf_a1 = in_rs1;
  assign rf_a2 = in_rs2;

  always_comb begin
    live1 = in_use_rs1 && (in_rs1 != 5'd0);
    live2 = in_use_rs2 && (in_rs2 != 5'd0);
`ifdef ID_EX_BYPASS_EN
    // Only results that cannot be bypassed yet block issue.
    haz1 = live1 && ((out_valid && out_rd_we && (out_rd == in_rs1)) ||
                     (mem_we && mem_is_load && (mem_rd == in_rs1)));
    haz2 = live2 && ((out_valid && out_rd_we && (out_rd == in_rs2)) ||
                     (mem_we && mem_is_load && (mem_rd == in_rs2)));
`else
    // Any in-flight writer blocks issue until the register file holds its result.
    haz1 = live1 && ((out_valid && out_rd_we && (out_rd == in_rs1)) ||
                     (mem_we && (mem_rd == in_rs1)) ||
                     (wb_we && (wb_rd == in_rs1)));
    haz2 = live2 && ((out_valid && out_rd_we && (out_rd == in_rs2)) ||
                     (mem_we && (mem_rd == in_rs2)) ||
                     (wb_we && (wb_rd == in_rs2)));
`endif
  end

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !haz1 && !haz2 && !flush;
  assign capture  = in_valid && in_ready;

  always_comb begin
    op1 = rf_d1;
    op2 = rf_d2;
`ifdef ID_EX_BYPASS_EN
    // WB bypass is required: the RF write lands on the capture edge, so rf_dN is stale.
    if (live1) begin
      if (mem_we && !mem_is_load && (mem_rd == in_rs1)) op1 = mem_wd;
      else if (wb_we && (wb_rd == in_rs1))               op1 = wb_wd;
    end
    if (live2) begin
      if (mem_we && !mem_is_load && (mem_rd == in_rs2)) op2 = mem_wd;
      else if (wb_we && (wb_rd == in_rs2))               op2 = wb_wd;
    end
`endif
    if (in_rs1 == 5'd0) op1 = '0;
    if (in_rs2 == 5'd0) op2 = '0;
  end

`ifndef ID_EX_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{mem_wd, wb_wd, mem_is_load};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_op1     <= '0;
      out_op2     <= '0;
      out_imm     <= '0;
      out_rd      <= '0;
      out_rd_we   <= 1'b0;
      out_is_load <= 1'b0;
      out_ctrl    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_op1     <= op1;
      out_op2     <= op2;
      out_imm     <= in_imm;
      out_rd      <= in_rd;
      out_rd_we   <= in_rd_we;
      out_is_load <= in_is_load;
      out_ctrl    <= in_ctrl;
    end else if (adv) begin
      // Consumed without refill, or bubble: payload holds, valid drops.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow ID_EX_BYPASS_EN.
module tb_id_ex_stage;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic [XLEN-1:0]   in_pc, in_imm;
  logic [4:0]        in_rs1, in_rs2, in_rd;
  logic              in_use_rs1, in_use_rs2, in_rd_we, in_is_load;
  logic [CTRL_W-1:0] in_ctrl;
  logic [4:0]        rf_a1, rf_a2;
  logic [XLEN-1:0]   rf_d1, rf_d2;
  logic [4:0]        mem_rd, wb_rd;
  logic              mem_we, mem_is_load, wb_we;
  logic [XLEN-1:0]   mem_wd, wb_wd;
  logic              flush;
  logic              out_valid, out_ready;
  logic [XLEN-1:0]   out_pc, out_op1, out_op2, out_imm;
  logic [4:0]        out_rd;
  logic              out_rd_we, out_is_load;
  logic [CTRL_W-1:0] out_ctrl;

  int n_vec = 0;
  int n_err = 0;

  id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_rd_we(in_rd_we), .in_is_load(in_is_load), .in_ctrl(in_ctrl),
    .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_d1(rf_d1), .rf_d2(rf_d2),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_is_load(mem_is_load), .mem_wd(mem_wd),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_wd(wb_wd),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_is_load(out_is_load), .out_ctrl(out_ctrl)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ports;
    in_valid = 0; in_pc = '0; in_imm = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_use_rs1 = 0; in_use_rs2 = 0; in_rd_we = 0; in_is_load = 0; in_ctrl = '0;
    rf_d1 = '0; rf_d2 = '0;
    mem_rd = '0; mem_we = 0; mem_is_load = 0; mem_wd = '0;
    wb_rd = '0; wb_we = 0; wb_wd = '0;
    flush = 0; out_ready = 1;
  endtask

  task automatic put(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic u1, input logic u2, input logic we,
                     input logic ld, input logic [31:0] imm, input logic [15:0] ctrl);
    in_valid = 1; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_use_rs1 = u1; in_use_rs2 = u2; in_rd_we = we; in_is_load = ld;
    in_imm = imm; in_ctrl = ctrl;
  endtask

  task automatic drain;
    in_valid = 0; mem_we = 0; wb_we = 0; out_ready = 1;
    tick;
  endtask

  task automatic test_reset;
    clear_ports;
    rst = 1;
    tick; tick;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", out_valid); end
    n_vec++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc got %h want 0", out_pc); end
    rst = 0;
    put(32'h100, 5'd1, 5'd2, 5'd3, 1, 1, 1, 0, 32'h44, 16'hABCD);
    rf_d1 = 32'd11; rf_d2 = 32'd22;
    tick;
    n_vec++; if (out_pc !== 32'h100) begin n_err++; $display("FAIL cap_pc got %h want 100", out_pc); end
    n_vec++; if (out_ctrl !== 16'hABCD) begin n_err++; $display("FAIL cap_ctrl got %h want abcd", out_ctrl); end
    // Stall with a second instruction waiting, then reset in the middle of it.
    out_ready = 0;
    put(32'h104, 5'd1, 5'd2, 5'd4, 1, 1, 1, 0, 32'h48, 16'h1111);
    tick;
    rst = 1;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %b want 0", out_valid); end
    n_vec++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL midrst_pc got %h want 0", out_pc); end
    n_vec++; if (out_op1 !== 32'h0 || out_op2 !== 32'h0)
      begin n_err++; $display("FAIL midrst_ops got %h/%h want 0/0", out_op1, out_op2); end
    n_vec++; if (out_ctrl !== 16'h0 || out_imm !== 32'h0 || out_rd !== 5'd0 || out_rd_we !== 1'b0)
      begin n_err++; $display("FAIL midrst_fields ctrl=%h imm=%h rd=%0d we=%b want zeros",
                              out_ctrl, out_imm, out_rd, out_rd_we); end
    tick;
    rst = 0;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL postrst_ready got %b want 1", in_ready); end
    tick;
    n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'h104)
      begin n_err++; $display("FAIL postrst_cap valid=%b pc=%h want 1/104", out_valid, out_pc); end
    drain;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    clear_ports;
    for (int i = 0; i < 3; i++) begin
      put(32'h200 + 32'(4 * i), 5'(10 + i), 5'(20 + i), 5'(28 + i), 1, 1, 1, 0,
          32'h30 + 32'(i), 16'h1000 + 16'(i));
      rf_d1 = 32'h1000_0000 + 32'(i);
      rf_d2 = 32'h2000_0000 + 32'(i);
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready); end
      tick;
      n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'h200 + 32'(4 * i))
        begin n_err++; $display("FAIL b2b_pc[%0d] valid=%b pc=%h want 1/%h", i, out_valid, out_pc,
                                32'h200 + 32'(4 * i)); end
      n_vec++; if (out_op1 !== 32'h1000_0000 + 32'(i) || out_op2 !== 32'h2000_0000 + 32'(i))
        begin n_err++; $display("FAIL b2b_ops[%0d] got %h/%h", i, out_op1, out_op2); end
      n_vec++; if (out_imm !== 32'h30 + 32'(i) || out_ctrl !== 16'h1000 + 16'(i) || out_rd !== 5'(28 + i))
        begin n_err++; $display("FAIL b2b_fields[%0d] imm=%h ctrl=%h rd=%0d", i, out_imm, out_ctrl, out_rd); end
    end
    drain;
  endtask

  task automatic test_x0;
    clear_ports;
    put(32'h300, 5'd0, 5'd9, 5'd12, 1, 1, 1, 0, 32'h0, 16'h0);
    mem_we = 1; mem_rd = 5'd0; mem_wd = 32'h1234; mem_is_load = 0;
    rf_d1 = 32'h0; rf_d2 = 32'hAAAA;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready got %b want 1", in_ready); end
    tick;
    n_vec++; if (out_valid !== 1'b1 || out_op1 !== 32'h0)
      begin n_err++; $display("FAIL x0_op1 valid=%b op1=%h want 1/0", out_valid, out_op1); end
    n_vec++; if (out_op2 !== 32'hAAAA) begin n_err++; $display("FAIL x0_op2 got %h want aaaa", out_op2); end
    drain;
  endtask

  task automatic test_dead_operand;
    clear_ports;
    put(32'h340, 5'd3, 5'd5, 5'd13, 1, 0, 1, 0, 32'h0, 16'h0);
    mem_we = 1; mem_is_load = 1; mem_rd = 5'd5; mem_wd = 32'h777;
    rf_d1 = 32'h31; rf_d2 = 32'h52;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL dead_ready got %b want 1", in_ready); end
    tick;
    n_vec++; if (out_op1 !== 32'h31 || out_op2 !== 32'h52)
      begin n_err++; $display("FAIL dead_ops got %h/%h want 31/52", out_op1, out_op2); end
    drain;
  endtask

  task automatic test_alu_dep;
    clear_ports;
    put(32'h400, 5'd0, 5'd0, 5'd5, 1, 0, 1, 0, 32'h10, 16'h0);   // addi x5, x0, 16
    tick;
    put(32'h404, 5'd5, 5'd5, 5'd6, 1, 1, 1, 0, 32'h0, 16'h0);    // add x6, x5, x5
    rf_d1 = 32'h99; rf_d2 = 32'h99;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL alu_haz_ex got %b want 0", in_ready); end
    tick;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL alu_bubble got %b want 0", out_valid); end
    mem_we = 1; mem_rd = 5'd5; mem_wd = 32'h10; mem_is_load = 0;
    #1;
`ifdef ID_EX_BYPASS_EN
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL alu_mem_ready got %b want 1", in_ready); end
    tick;
`else
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL alu_mem_stall got %b want 0", in_ready); end
    tick;
    mem_we = 0; wb_we = 1; wb_rd = 5'd5; wb_wd = 32'h10;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL alu_wb_stall got %b want 0", in_ready); end
    tick;
    wb_we = 0; rf_d1 = 32'h10; rf_d2 = 32'h10;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL alu_rf_ready got %b want 1", in_ready); end
    tick;
`endif
    n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'h404)
      begin n_err++; $display("FAIL alu_cap valid=%b pc=%h want 1/404", out_valid, out_pc); end
    n_vec++; if (out_op1 !== 32'h10 || out_op2 !== 32'h10)
      begin n_err++; $display("FAIL alu_ops got %h/%h want 10/10", out_op1, out_op2); end
    drain;
  endtask

  task automatic test_load_dep;
    clear_ports;
    put(32'h500, 5'd2, 5'd0, 5'd7, 1, 0, 1, 1, 32'h0, 16'h0);    // lw x7, 0(x2)
    rf_d1 = 32'h1000;
    tick;
    put(32'h504, 5'd8, 5'd7, 5'd9, 1, 1, 1, 0, 32'h0, 16'h0);    // add x9, x8, x7
    rf_d1 = 32'h88; rf_d2 = 32'h0;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ld_haz_ex got %b want 0", in_ready); end
    tick;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ld_bubble1 got %b want 0", out_valid); end
    mem_we = 1; mem_is_load = 1; mem_rd = 5'd7; mem_wd = 32'h5000;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ld_haz_mem got %b want 0", in_ready); end
    tick;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ld_bubble2 got %b want 0", out_valid); end
    mem_we = 0; mem_is_load = 0; wb_we = 1; wb_rd = 5'd7; wb_wd = 32'hDEAD_BEEF;
    #1;
`ifdef ID_EX_BYPASS_EN
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ld_wb_ready got %b want 1", in_ready); end
    tick;
`else
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ld_wb_stall got %b want 0", in_ready); end
    tick;
    wb_we = 0; rf_d2 = 32'hDEAD_BEEF;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ld_rf_ready got %b want 1", in_ready); end
    tick;
`endif
    n_vec++; if (out_valid !== 1'b1 || out_op2 !== 32'hDEAD_BEEF)
      begin n_err++; $display("FAIL ld_op2 valid=%b op2=%h want 1/deadbeef", out_valid, out_op2); end
    n_vec++; if (out_op1 !== 32'h88) begin n_err++; $display("FAIL ld_op1 got %h want 88", out_op1); end
    drain;
  endtask

  task automatic test_stall_flush;
    clear_ports;
    put(32'h600, 5'd1, 5'd2, 5'd3, 1, 1, 1, 0, 32'h6, 16'h6666);
    rf_d1 = 32'h61; rf_d2 = 32'h62;
    tick;
    out_ready = 0;
    put(32'h604, 5'd4, 5'd11, 5'd10, 1, 1, 1, 0, 32'h7, 16'h7777);
    rf_d1 = 32'h71; rf_d2 = 32'h72;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready got %b want 0", in_ready); end
    tick;
    n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'h600 || out_op1 !== 32'h61 || out_ctrl !== 16'h6666)
      begin n_err++; $display("FAIL stall_hold valid=%b pc=%h op1=%h ctrl=%h want 1/600/61/6666",
                              out_valid, out_pc, out_op1, out_ctrl); end
    flush = 1;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready got %b want 0", in_ready); end
    tick;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", out_valid); end
    n_vec++; if (out_pc !== 32'h600) begin n_err++; $display("FAIL flush_pc got %h want 600", out_pc); end
    flush = 0; in_valid = 0;
    tick;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_drop got %b want 0", out_valid); end
    drain;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_back_to_back;
    test_x0;
    test_dead_operand;
    test_alu_dep;
    test_load_dep;
    test_stall_flush;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
